// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide, 32 cycles per op, with a fast path for divide-by-zero and signed overflow.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [4:0] count, rd;
  logic [2:0] f3;
  logic s1, s2, sg1, sg2, accept, fast, last;
  logic [31:0] a, b, quo, quo_nxt, abs1, abs2, fast_res, calc_res, q, r;
  logic [63:0] acc, acc_nxt, prod;
  logic [32:0] rem, rem_nxt, sum, t;
  logic [33:0] diff;

  assign accept  = state == IDLE && start_i && !flush_i;
  assign last    = state == CALC && count == 5'd31;
  assign busy_o  = accept || state == CALC;
  assign valid_o = state == DONE && !flush_i;

  always_comb begin
    sg1 = op1_i[31] & ~(funct3_i[0] & (funct3_i[1] | funct3_i[2]));
    sg2 = op2_i[31] & ((funct3_i[2:1] == 2'b00) | (funct3_i[2] & ~funct3_i[0]));
    abs1 = sg1 ? -op1_i : op1_i;
    abs2 = sg2 ? -op2_i : op2_i;
    fast = funct3_i[2] & ((op2_i == 32'd0) | (~funct3_i[0] & op1_i == 32'h8000_0000 & op2_i == 32'hffff_ffff));
    fast_res = op2_i == 32'd0 ? (funct3_i[1] ? op1_i : 32'hffff_ffff) : (funct3_i[1] ? 32'd0 : 32'h8000_0000);
  end

  // One shift-add multiply step and one restoring divide step run side by side; f3 picks the result.
  always_comb begin
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a} : 33'd0);
    acc_nxt = {sum, acc[31:1]};
    t = {rem[31:0], quo[31]};
    diff = {1'b0, t} - {2'b0, b};
    rem_nxt = diff[33] ? t : diff[32:0];
    quo_nxt = {quo[30:0], ~diff[33]};
    prod = (s1 ^ s2) ? -acc_nxt : acc_nxt;
    q = (s1 ^ s2) ? -quo_nxt : quo_nxt;
    r = s1 ? -rem_nxt[31:0] : rem_nxt[31:0];
    calc_res = f3[2] ? (f3[1] ? r : q) : (f3 == 3'd0 ? prod[31:0] : prod[63:32]);
  end

  always_comb begin
    state_nxt = state;
    state_nxt = flush_i ? IDLE :
                state == IDLE ? (start_i ? (fast ? DONE : CALC) : IDLE) :
                state == CALC ? (count == 5'd31 ? DONE : CALC) : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rd <= '0;
      f3 <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      a <= '0;
      b <= '0;
      acc <= '0;
      rem <= '0;
      quo <= '0;
      result_o <= '0;
      rd_addr_o <= '0;
    end else begin
      if (accept) begin
        f3 <= funct3_i;
        rd <= rd_addr_i;
        s1 <= sg1;
        s2 <= sg2;
        a <= abs1;
        b <= abs2;
        count <= '0;
        acc <= {32'd0, abs2};
        rem <= '0;
        quo <= abs1;
      end else if (state == CALC) begin
        count <= count + 5'd1;
        acc <= acc_nxt;
        rem <= rem_nxt;
        quo <= quo_nxt;
      end
      if (accept && fast) begin
        result_o <= fast_res;
        rd_addr_o <= rd_addr_i;
      end else if (last && !flush_i) begin
        result_o <= calc_res;
        rd_addr_o <= rd;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against a plain-arithmetic RV32M model.
module tb_ex_muldiv;
  logic clk = 0, rst = 1, start_i = 0, flush_i = 0;
  logic [2:0] funct3_i = 0;
  logic [31:0] op1_i = 0, op2_i = 0;
  logic [4:0] rd_addr_i = 0;
  logic busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0] rd_addr_o;
  int tests = 0, fails = 0;
  logic exp_busy = 0, exp_valid = 0;
  logic [31:0] exp_res = 0;
  logic [4:0] exp_rd = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i), .op1_i(op1_i),
    .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i), .busy_o(busy_o),
    .valid_o(valid_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint xs, ys, xu, yu, p;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    xu = longint'({32'd0, x});
    yu = longint'({32'd0, y});
    case (f)
      3'd0: p = xs * ys;
      3'd1: p = (xs * ys) >>> 32;
      3'd2: p = (xs * yu) >>> 32;
      3'd3: p = (xu * yu) >> 32;
      3'd4: p = y == 0 ? -1 : xs / ys;
      3'd5: p = y == 0 ? -1 : xu / yu;
      3'd6: p = y == 0 ? xu : xs % ys;
      default: p = y == 0 ? xu : xu % yu;
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && (y == 0 || ((f == 4 || f == 6) && x == 32'h8000_0000 && y == 32'hffff_ffff));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("busy_o", 32'(busy_o), 32'(exp_busy));
    chk("valid_o", 32'(valid_o), 32'(exp_valid));
    chk("result_o", result_o, exp_res);
    chk("rd_addr_o", 32'(rd_addr_o), 32'(exp_rd));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1 of an idle cycle; that cycle becomes cycle 0.
  task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] rdv, input int fl);
    int lat;
    logic [31:0] res;
    lat = is_fast(f, x, y) ? 1 : 33;
    res = model(f, x, y);
    if (lat == 1) fl = -1;
    start_i = 1; flush_i = 0; funct3_i = f; op1_i = x; op2_i = y; rd_addr_i = rdv;
    exp_busy = 1; exp_valid = 0;
    for (int c = 1; c <= lat; c++) begin
      tick();
      start_i = 1'($urandom_range(0, 1));
      funct3_i = 3'($urandom); op1_i = $urandom; op2_i = $urandom; rd_addr_i = 5'($urandom);
      if (c == fl) begin
        flush_i = 1; exp_busy = 1; exp_valid = 0;
        tick();
        flush_i = 0; start_i = 0; exp_busy = 0;
        return;
      end
      exp_busy = c < lat;
      exp_valid = c == lat;
      if (c == lat) begin
        exp_res = res;
        exp_rd = rdv;
      end
    end
    tick();
    start_i = 0; exp_busy = 0; exp_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("pin_mul", model(0, 7, 32'hffff_fffd), 32'hffff_ffeb);
    chk("pin_mulhu", model(3, 32'hffff_ffff, 32'hffff_ffff), 32'hffff_fffe);
    chk("pin_mulh", model(1, 32'hffff_ffff, 32'hffff_ffff), 32'h0);
    chk("pin_mulhsu", model(2, 32'hffff_ffff, 2), 32'hffff_ffff);
    chk("pin_div", model(4, 32'hffff_fff9, 2), 32'hffff_fffd);
    chk("pin_rem", model(6, 32'hffff_fff9, 2), 32'hffff_ffff);
    chk("pin_divu", model(5, 100, 7), 32'd14);
    chk("pin_remu", model(7, 100, 7), 32'd2);
    chk("pin_divu0", model(5, 5, 0), 32'hffff_ffff);
    chk("pin_div_ovf", model(4, 32'h8000_0000, 32'hffff_ffff), 32'h8000_0000);
    chk("pin_rem_ovf", model(6, 32'h8000_0000, 32'hffff_ffff), 32'h0);
    tick();
    run(0, 7, 32'hffff_fffd, 5'd9, -1);
    run(3, 32'hffff_ffff, 32'hffff_ffff, 5'd1, -1);
    run(1, 32'hffff_ffff, 32'hffff_ffff, 5'd2, -1);
    run(2, 32'hffff_ffff, 2, 5'd3, -1);
    run(4, 32'hffff_fff9, 2, 5'd4, -1);
    run(6, 32'hffff_fff9, 2, 5'd5, -1);
    run(5, 100, 7, 5'd6, -1);
    run(7, 100, 7, 5'd7, -1);
    run(5, 5, 0, 5'd8, -1);
    run(6, 32'h8000_0000, 32'hffff_ffff, 5'd10, -1);
    run(4, 32'h8000_0000, 32'hffff_ffff, 5'd11, -1);
    run(7, 32'h1234_5678, 0, 5'd12, -1);
    run(4, 32'd1000, 32'd3, 5'd13, 10);
    repeat (40) tick();
    run(0, 32'd123, 32'd456, 5'd14, -1);
    run(5, 32'd77, 32'd5, 5'd15, 32);
    repeat (5) tick();
    start_i = 1; flush_i = 1; funct3_i = 0; op1_i = 3; op2_i = 3;
    tick();
    start_i = 0; flush_i = 0;
    repeat (3) tick();
    start_i = 1; funct3_i = 0; op1_i = 32'd1000; op2_i = 32'd1000; rd_addr_i = 5'd20;
    exp_busy = 1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start_i = 0;
    end
    rst = 1;
    exp_busy = 0; exp_valid = 0; exp_res = 0; exp_rd = 0;
    #1;
    chk("rst_async_result", result_o, 32'd0);
    chk("rst_async_busy", 32'(busy_o), 32'd0);
    chk("rst_async_rd", 32'(rd_addr_o), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    repeat (40) tick();
    run(0, 32'hffff_fff0, 32'd3, 5'd21, -1);
    for (int i = 0; i < 200; i++)
      run(3'($urandom), pick(), pick(), 5'($urandom), $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 32)) : -1);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the registered operands (op1/op2), rd address and a decoded M-extension function code, and computes one result over 32 cycles. While busy it raises a hold request toward control, which freezes the front of the pipeline. The result is presented as a one-cycle valid pulse for the EX write-back mux.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  request: an M instruction sits in EX this cycle.
- funct3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1_i  in  32  rs1 operand (dividend / multiplicand).
- op2_i  in  32  rs2 operand (divisor / multiplier).
- rd_addr_i  in  5  destination register.
- flush_i  in  1  kill the in-flight operation (jump/trap from control).
- busy_o  out  1  hold request to control.
- valid_o  out  1  result_o/rd_addr_o valid; one-cycle pulse.
- result_o  out  32  final result.
- rd_addr_o  out  5  destination register of the result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE with start_i=1 and flush_i=0: latch funct3, rd_addr, the sign flags and the absolute values of the operands.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats op1 as signed and op2 as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - Go to CALC with count=0, except for the special cases below.
- Special cases (fast path) go IDLE->DONE directly:
  - Divide by zero (op2=0, funct3 4-7): DIV/DIVU return 0xFFFFFFFF. REM/REMU return op1.
  - Signed overflow (funct3 4/6, op1=0x80000000, op2=0xFFFFFFFF): DIV returns 0x80000000. REM returns 0.
- Multiply in CALC: unsigned shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- Divide in CALC: restoring division, one quotient bit per cycle. It keeps a 33-bit partial remainder and a 32-bit quotient.
- count increments each CALC cycle. The step at count=31 is the last, and the next state is DONE.
- Entering DONE: apply sign correction.
  - Product negated if (s1 XOR s2) for signed modes.
  - Quotient negated if s1 XOR s2.
  - Remainder takes the sign of the dividend (negated if s1).
- Result selection: MUL gives the low 32 bits. MULH/MULHSU/MULHU give the high 32 bits.
- DONE: valid_o=1 and result_o/rd_addr_o driven. The next state is always IDLE.
- busy_o = (IDLE and start_i and not flush_i) or CALC. busy_o is low in DONE so the pipeline advances and captures the result.
- start_i is ignored outside IDLE.
- flush_i in CALC or DONE:
  - The next state is IDLE and valid_o is forced low that cycle.
  - No result is produced.
  - The start_i in that same cycle is not accepted.
- result_o and rd_addr_o hold their last values when valid_o=0.

## Timing
- Reset (async): state IDLE, count 0. busy_o=0, valid_o=0, result_o=0, rd_addr_o=0, all internal registers 0.
- Normal op: start_i high in cycle 0 (busy_o=1 combinationally).
  - Cycles 1..32 are CALC (busy_o=1).
  - Cycle 33 is DONE: valid_o=1, busy_o=0.
  - The next start is accepted no earlier than cycle 34.
- Fast path: start in cycle 0 (busy_o=1), DONE in cycle 1 (valid_o=1, busy_o=0).
- Back-to-back: start_i asserted during DONE is ignored. Control re-presents the next instruction, which is accepted in the following IDLE cycle.
- Reset asserted mid-CALC: all outputs go to reset values immediately, with no valid pulse.
- flush_i and the final CALC step in the same cycle: the flush wins and no valid pulse follows.

## Test plan
- MUL op1=7, op2=0xFFFFFFFD (-3) -> valid_o in cycle 33 exactly, result_o=0xFFFFFFEB, rd_addr_o echoes input; busy_o high cycles 0-32.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH of the same operands -> 0x00000000. MULHSU op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> 0xFFFFFFFD. REM of the same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with valid_o in cycle 1. REM 0x80000000/0xFFFFFFFF -> 0 with valid_o in cycle 1.
- Flush: start DIV, assert flush_i in cycle 10 -> busy_o=0 from cycle 11, no valid_o for 40 cycles. A new MUL started afterwards completes correctly.
- Async rst pulse in cycle 15 of a MUL -> outputs 0 immediately, no valid_o. A subsequent op gives the correct result and latency.
